// File: rtl/data_mem_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_pkg                                                          |
// | Brief   : Shared funct3 codes, FSM state encoding and byte-swap helper for |
// |           the data memory load/store unit.                                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2
  } lsu_state_t;

  // The RAM stores mem[A] in the top byte; reversing the bytes gives the
  // little-endian architectural view (and vice versa for writes).
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_lsu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : data_mem_lsu_if                                                  |
// | Brief   : Request/response bus between the execute stage and the LSU.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_lsu_lane_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_lane_mux                                                     |
// | Brief   : Combinational byte-lane extract/extend for loads and merge for   |
// |           sub-word stores, operating on little-endian words.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] ld_aw,
  input  logic [31:0] st_aw,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte/halfword and sign- or zero-extend it.
  always_comb begin
    w_byte   = ld_aw[7:0];
    w_half   = offset[1] ? ld_aw[31:16] : ld_aw[15:0];
    load_val = '0;
    case (offset)
      2'd0:    w_byte = ld_aw[7:0];
      2'd1:    w_byte = ld_aw[15:8];
      2'd2:    w_byte = ld_aw[23:16];
      default: w_byte = ld_aw[31:24];
    endcase
    case (funct3)
      F3_B:    load_val = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_val = {24'd0, w_byte};
      F3_H:    load_val = {{16{w_half[15]}}, w_half};
      F3_HU:   load_val = {16'd0, w_half};
      F3_W:    load_val = ld_aw;
      default: load_val = '0;
    endcase
  end

  // Replace only the targeted byte/halfword of the previously read word.
  always_comb begin
    store_word = wdata;
    case (funct3)
      F3_B: begin
        store_word = st_aw;
        case (offset)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        store_word = st_aw;
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : data_mem_lsu                                                     |
// | Brief   : Load/store unit between execute stage and byte-addressed data    |
// |           RAM. Optional perf counters enabled by LSU_PERF_CNT_EN.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  data_mem_lsu_if.slave            bus,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]              cnt_load,
  output logic [31:0]              cnt_store,
  output logic [31:0]              cnt_err
`endif
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_CHECK = CHECK;
  localparam logic [1:0] S_WRITE = WRITE;

  logic [1:0]               r_state;
  logic                     r_we;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [31:0]              r_aw;
  logic                     r_rsp_valid;
  logic [31:0]              r_rsp_rdata;
  logic                     r_rsp_err;

  logic [ADDRESS_WIDTH-1:0] w_req_addr;
  logic [31:0]              w_aw;
  logic [31:0]              w_load;
  logic [31:0]              w_store_word;
  logic                     w_err;
  logic                     w_rmw;

  // Upper address bits beyond the RAM are dropped so addresses wrap.
  generate
    if (ADDRESS_WIDTH < 32) begin : g_addr_trunc
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^bus.req_addr[31:ADDRESS_WIDTH];
      assign w_req_addr       = bus.req_addr[ADDRESS_WIDTH-1:0];
    end else begin : g_addr_full
      assign w_req_addr = bus.req_addr;
    end
  endgenerate

  assign w_aw = bswap32(mem_rd);

  // Illegal funct3, signed-store encodings and misaligned word/half accesses.
  always_comb begin
    w_err = (r_funct3 == 3'b011) || (r_funct3[2:1] == 2'b11)
         || (r_we && r_funct3[2])
         || ((r_funct3 == F3_W) && (r_addr[1:0] != 2'b00))
         || ((r_funct3[1:0] == 2'b01) && r_addr[0]);
    w_rmw = r_we && !w_err && ((r_funct3 == F3_B) || (r_funct3 == F3_H));
  end

  lsu_lane_mux u_lane_mux (
    .ld_aw      (w_aw),
    .st_aw      (r_aw),
    .wdata      (r_wdata),
    .funct3     (r_funct3),
    .offset     (r_addr[1:0]),
    .load_val   (w_load),
    .store_word (w_store_word)
  );

  // RAM side is driven only from latched state so it cannot glitch with the bus.
  assign mem_a         = {r_addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign mem_we        = ((r_state == S_CHECK) && r_we && !w_err && !w_rmw)
                      || (r_state == S_WRITE);
  assign mem_wd        = bswap32((r_state == S_WRITE) ? w_store_word : r_wdata);
  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  // Request latch, access sequencing and response generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_aw        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= w_req_addr;
            r_wdata  <= bus.req_wdata;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_rmw) begin
            r_aw    <= w_aw;
            r_state <= S_WRITE;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
            r_state     <= S_IDLE;
          end
        end
        S_WRITE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'd0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic w_inc_load;
  logic w_inc_store;
  logic w_inc_err;

  assign w_inc_load  = (r_state == S_CHECK) && !w_rmw && !w_err && !r_we;
  assign w_inc_store = ((r_state == S_CHECK) && !w_rmw && !w_err && r_we)
                    || (r_state == S_WRITE);
  assign w_inc_err   = (r_state == S_CHECK) && w_err;

  // Saturating counters, stepped on the edge that raises the matching response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_err   <= '0;
    end else begin
      if (w_inc_load  && (cnt_load  != 32'hFFFF_FFFF)) cnt_load  <= cnt_load  + 32'd1;
      if (w_inc_store && (cnt_store != 32'hFFFF_FFFF)) cnt_store <= cnt_store + 32'd1;
      if (w_inc_err   && (cnt_err   != 32'hFFFF_FFFF)) cnt_err   <= cnt_err   + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_data_mem_lsu                                                  |
// | Brief   : Scoreboard bench for data_mem_lsu with a byte-array RAM model.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_data_mem_lsu;
  import lsu_pkg::*;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_lsu_if bus();

  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;
`ifdef LSU_PERF_CNT_EN
  logic [31:0]   cnt_load, cnt_store, cnt_err;
  int            m_load = 0, m_store = 0, m_err = 0;
`endif

  data_mem_lsu #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .mem_a  (mem_a),
    .mem_we (mem_we),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
`ifdef LSU_PERF_CNT_EN
    ,
    .cnt_load  (cnt_load),
    .cnt_store (cnt_store),
    .cnt_err   (cnt_err)
`endif
  );

  // RAM model: mem[A] sits in the top byte of the read word.
  logic [7:0] ram [0:(1<<AW)-1];
  assign mem_rd = {ram[mem_a], ram[mem_a + 12'd1], ram[mem_a + 12'd2], ram[mem_a + 12'd3]};
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_a]         <= mem_wd[31:24];
      ram[mem_a + 12'd1] <= mem_wd[23:16];
      ram[mem_a + 12'd2] <= mem_wd[15:8];
      ram[mem_a + 12'd3] <= mem_wd[7:0];
    end
  end

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    time         acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_wd = '0;
  bit          err_phase = 1'b0;
  int          we_in_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      last_wd = mem_wd;
      if (err_phase) we_in_err++;
    end
    if (bus.rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual rdata=%h err=%b required none",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.name, "_rdata"}, bus.rsp_rdata, mon_e.rdata);
        chk({mon_e.name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
        chk({mon_e.name, "_latency"}, 32'($time - mon_e.acc), 32'(mon_e.lat * 10 + 5));
      end
    end
  end

  // Present one request (called at a falling edge) and queue its expected response.
  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit hold);
    exp_t e;
    int   n;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept actual=timeout required=req_ready", name);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.name  = name;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.acc   = $time;
    e.lat   = lat;
    q.push_back(e);
`ifdef LSU_PERF_CNT_EN
    if (exp_err) m_err++;
    else if (we) m_store++;
    else m_load++;
`endif
    @(negedge clk);
    chk({name, "_busy"}, {31'd0, bus.req_ready}, 32'd0);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d_pending required=0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a",     32'(mem_a), 32'd0);
    chk("rst_mem_wd",    mem_wd, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then readback, plus RAM byte order.
    issue("sw_100", 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, 1, 1'b0);
    drain();
    chk("sw_mem_wd", last_wd, 32'hEFBEADDE);
    chk("sw_raw_byte", {24'd0, ram[12'h100]}, 32'h0000_00EF);
    issue("lw_100",  1'b0, F3_W,  32'h100, 32'd0, 32'hDEADBEEF, 1'b0, 1, 1'b0);
    issue("lb_103",  1'b0, F3_B,  32'h103, 32'd0, 32'hFFFFFFDE, 1'b0, 1, 1'b0);
    issue("lbu_103", 1'b0, F3_BU, 32'h103, 32'd0, 32'h000000DE, 1'b0, 1, 1'b0);
    issue("lh_102",  1'b0, F3_H,  32'h102, 32'd0, 32'hFFFFDEAD, 1'b0, 1, 1'b0);
    issue("lhu_100", 1'b0, F3_HU, 32'h100, 32'd0, 32'h0000BEEF, 1'b0, 1, 1'b0);
    issue("lw_wrap", 1'b0, F3_W,  32'hFFFF_F100, 32'd0, 32'hDEADBEEF, 1'b0, 1, 1'b0);
    drain();

    // Sub-word read-modify-write.
    issue("sb_101",   1'b1, F3_B, 32'h101, 32'h12,   32'd0, 1'b0, 2, 1'b0);
    issue("lw_sb",    1'b0, F3_W, 32'h100, 32'd0, 32'hDEAD12EF, 1'b0, 1, 1'b0);
    issue("sh_102",   1'b1, F3_H, 32'h102, 32'h5678, 32'd0, 1'b0, 2, 1'b0);
    issue("lw_sh",    1'b0, F3_W, 32'h100, 32'd0, 32'h567812EF, 1'b0, 1, 1'b0);
    drain();

    // Error cases: no RAM write, zero data, two-cycle response.
    err_phase = 1'b1;
    issue("lw_mis",  1'b0, F3_W,   32'h102, 32'd0,    32'd0, 1'b1, 1, 1'b0);
    issue("sh_mis",  1'b1, F3_H,   32'h101, 32'h5678, 32'd0, 1'b1, 1, 1'b0);
    issue("f3_011",  1'b0, 3'b011, 32'h100, 32'd0,    32'd0, 1'b1, 1, 1'b0);
    issue("st_f3bu", 1'b1, F3_BU,  32'h100, 32'hAA,   32'd0, 1'b1, 1, 1'b0);
    drain();
    err_phase = 1'b0;
    chk("err_no_mem_we", 32'(we_in_err), 32'd0);

    // Reset while an SB is in its write cycle.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'hAA;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_write_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rstmid_ready",  {31'd0, bus.req_ready}, 32'd1);
`ifdef LSU_PERF_CNT_EN
    m_load = 0; m_store = 0; m_err = 0;
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue("lw_after_rst", 1'b0, F3_W, 32'h100, 32'd0, 32'h567812EF, 1'b0, 1, 1'b0);
    drain();

    // Back-to-back requests with req_valid held high.
    issue("b2b_sw",  1'b1, F3_W,  32'h200, 32'h11223344, 32'd0, 1'b0, 1, 1'b1);
    issue("b2b_lw0", 1'b0, F3_W,  32'h200, 32'd0, 32'h11223344, 1'b0, 1, 1'b1);
    issue("b2b_sb",  1'b1, F3_B,  32'h201, 32'h99, 32'd0, 1'b0, 2, 1'b1);
    issue("b2b_lw1", 1'b0, F3_W,  32'h200, 32'd0, 32'h11229944, 1'b0, 1, 1'b1);
    issue("b2b_lhu", 1'b0, F3_HU, 32'h202, 32'd0, 32'h00001122, 1'b0, 1, 1'b1);
    issue("b2b_lb",  1'b0, F3_B,  32'h200, 32'd0, 32'h00000044, 1'b0, 1, 1'b0);
    drain();

`ifdef LSU_PERF_CNT_EN
    chk("cnt_load",  cnt_load,  32'(m_load));
    chk("cnt_store", cnt_store, 32'(m_store));
    chk("cnt_err",   cnt_err,   32'(m_err));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
